// File: rtl/risc16_pkg.sv
// Shared RisC-16 constants and the fetch-responder state encoding.
package risc16_pkg;

    localparam int unsigned      WORD_W   = 16;
    localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous program store with registered read data.
module imem_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    logic [WORD_W-1:0] rdata_q;

    // Read register only updates on a read, so data holds across stalls.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: boot-time program load, then 1-cycle fetch
// responses over a valid/ready channel with flush support.
module imem_fetch_responder
    import risc16_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 8,
    parameter int unsigned        WORD_W   = risc16_pkg::WORD_W,
    parameter logic [WORD_W-1:0]  NOP_WORD = risc16_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [15:0]       req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic [15:0]       rsp_addr,
    output logic              rsp_fault,
    input  logic              flush,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              running,
    output logic [ADDR_W:0]   ld_count
);

    localparam logic [ADDR_W:0] LD_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_addr_q, rsp_addr_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [ADDR_W:0]   ld_count_q, ld_count_d;
    logic              accept;
    logic [WORD_W-1:0] ram_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == BOOT && ld_valid && ld_last) begin
            state_d = RUN;
        end
    end

    always_comb begin
        running = (state_q == RUN);
    end

    assign req_ready = running && !ld_valid && (!rsp_valid_q || rsp_ready || flush);
    assign accept    = req_valid && req_ready;

    always_comb begin
        rsp_valid_d = rsp_valid_q && !rsp_ready && !flush;
        rsp_addr_d  = rsp_addr_q;
        rsp_fault_d = rsp_fault_q;
        ld_count_d  = ld_count_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_addr_d  = req_addr;
            rsp_fault_d = |req_addr[15:ADDR_W];
        end
        if (state_q == BOOT && ld_valid && ld_count_q != LD_MAX) begin
            ld_count_d = ld_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_fault_q <= 1'b0;
            ld_count_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_fault_q <= rsp_fault_d;
            ld_count_q  <= ld_count_d;
        end
    end

    // Loads block accepts, so one shared address port never sees both.
    imem_ram #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ld_valid),
        .re_i    (accept),
        .addr_i  (ld_valid ? ld_addr : req_addr[ADDR_W-1:0]),
        .wdata_i (ld_data),
        .rdata_o (ram_rdata)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_fault = rsp_fault_q;
    assign ld_count  = ld_count_q;
    assign rsp_data  = !rsp_valid_q ? '0 : (rsp_fault_q ? NOP_WORD : ram_rdata);

endmodule
